// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed hex seven-segment display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Value/control inputs and pin outputs of the seven-segment scanner.
// The slave side is the display driver; the master side feeds it and watches the pins.
interface seg7_scan_display_if;
  logic [15:0] d_in;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output d_in, blank_lz, dp_en,
    input  an, seg, dp
  );

  modport slave (
    input  d_in, blank_lz, dp_en,
    output an, seg, dp
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display driver with per-frame snapshot and leading-zero blanking.
// state | meaning: DIG0..DIG3 | digit k is the slot currently driven; DIG3 is the reset/idle slot.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_display_if.slave  disp
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  digit_e           digit_q, digit_d;
  logic [15:0]      frame_q, frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg_dec;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
      digit_q   <= DIG3;
      frame_q   <= 16'h0000;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    digit_d = digit_q;
    if (tick) begin
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG2;
        DIG2:    digit_d = DIG3;
        DIG3:    digit_d = DIG0;
        default: digit_d = DIG0;
      endcase
    end

    // Snapshot on the tick entering DIG0 so the whole frame shows one value.
    frame_d = (tick && digit_q == DIG3) ? disp.d_in : frame_q;

    nibble = frame_d[3:0];
    blank  = 1'b0;
    case (digit_d)
      DIG0: begin
        nibble = frame_d[3:0];
        blank  = 1'b0;
      end
      DIG1: begin
        nibble = frame_d[7:4];
        blank  = disp.blank_lz && (frame_d[15:4] == 12'h000);
      end
      DIG2: begin
        nibble = frame_d[11:8];
        blank  = disp.blank_lz && (frame_d[15:8] == 8'h00);
      end
      DIG3: begin
        nibble = frame_d[15:12];
        blank  = disp.blank_lz && (frame_d[15:12] == 4'h0);
      end
      default: begin
        nibble = frame_d[3:0];
        blank  = 1'b0;
      end
    endcase

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick) begin
      if (blank) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << digit_d);
        seg_d = seg_dec;
        dp_d  = ~disp.dp_en[digit_d];
      end
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule
